writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 224 ++++++++++++++++++++++
 tb/tb_writeback_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue
// ---------------
// Merges two register-bank write sources onto one registered write port:
//   * ALU results (no handshake, one-cycle latency, highest normal priority)
//   * load results, buffered in a DEPTH-entry FIFO (ld_valid / ld_ready).
// A starvation counter counts ALU wins while loads are waiting. At STARVE_MAX
// it raises alu_stall, and the head of the FIFO is written on the next edge
// even if the ALU keeps writing. An ALU write arriving while alu_stall is high
// is discarded and latches the sticky drop_err flag.
//
// Optional feature (compile-time macro WBQ_BYPASS_EN):
//   defined   - a load arriving at an empty FIFO on a cycle with no other
//               write selected goes straight to the write port (1 cycle).
//   undefined - every load is queued first (2-cycle minimum latency).
//
// Ports
//   clk        in   1   clock, all state on the rising edge
//   rst_n      in   1   asynchronous active-low reset; release is synchronized
//   alu_wen    in   1   ALU write request
//   alu_dest   in   3   ALU destination register
//   alu_data   in   32  ALU write data
//   ld_valid   in   1   load result offered
//   ld_dest    in   3   load destination register
//   ld_data    in   32  load data
//   ld_ready   out  1   FIFO not full
//   wEnable    out  1   registered register-bank write enable
//   DestReg    out  3   registered write address
//   WBDataIN   out  32  registered write data
//   alu_stall  out  1   registered; upstream must hold ALU writes
//   pend_mask  out  8   bit r set while a queued load targets register r
//   drop_err   out  1   sticky: an ALU write was discarded
module writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_wen,
    input  logic [2:0]  alu_dest,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    input  logic [2:0]  ld_dest,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        wEnable,
    output logic [2:0]  DestReg,
    output logic [31:0] WBDataIN,
    output logic        alu_stall,
    output logic [7:0]  pend_mask,
    output logic        drop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // ---------------- reset release synchronizer ----------------
    // Assertion is immediate; state only starts moving two edges after
    // rst_n rises, so every flop leaves reset on the same edge.
    logic sync1_reg, sync2_reg;
    logic run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= 1'b1;
            sync2_reg <= sync1_reg;
        end
    end

    assign run = sync2_reg;

    // ---------------- state ----------------
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [ST_W-1:0]  starve_reg, starve_next;
    logic             stall_reg, stall_next;
    logic             drop_reg, drop_next;
    logic             wen_reg, wen_next;
    logic [2:0]       dest_reg, dest_next;
    logic [31:0]      data_reg, data_next;

    // Entry storage: written on push, read into the output register on pop.
    logic [2:0]  dest_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    // ---------------- selection ----------------
    logic empty, full, accept, push, pop, alu_sel, drop, bypass;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_FULL);
    assign ld_ready = !full;

    // A load is only taken when ld_ready is high; during a full cycle the
    // pop frees a slot that becomes visible on the next cycle. Nothing is
    // accepted while the reset synchronizer is still releasing.
    assign accept  = run && ld_valid && !full;
    // Forced pop (stall) beats the ALU; otherwise the FIFO drains whenever
    // the ALU is idle.
    assign pop     = run && !empty && (stall_reg || !alu_wen);
    assign alu_sel = run && alu_wen && !stall_reg;
    assign drop    = run && alu_wen && stall_reg;

`ifdef WBQ_BYPASS_EN
    // Empty FIFO implies no pop, so only the ALU can claim the port.
    assign bypass = accept && empty && !alu_sel;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    // ---------------- next-state logic ----------------
    always_comb begin
        wen_next  = 1'b0;
        dest_next = dest_reg;
        data_next = data_reg;
        if (pop) begin
            wen_next  = 1'b1;
            dest_next = dest_mem[rd_ptr_reg];
            data_next = data_mem[rd_ptr_reg];
        end else if (alu_sel) begin
            wen_next  = 1'b1;
            dest_next = alu_dest;
            data_next = alu_data;
        end else if (bypass) begin
            wen_next  = 1'b1;
            dest_next = ld_dest;
            data_next = ld_data;
        end
    end

    always_comb begin
        wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Starvation only accumulates while loads are actually waiting.
    always_comb begin
        starve_next = starve_reg;
        if (pop || empty) begin
            starve_next = '0;
        end else if (alu_sel && (starve_reg < ST_MAX)) begin
            starve_next = starve_reg + ST_W'(1);
        end
        // Rises on the edge the counter saturates, falls on the forced-pop
        // edge because the pop clears the counter.
        stall_next = (starve_next == ST_MAX);
        drop_next  = drop_reg || drop;
    end

    // Per-entry valid bits keep pend_mask independent of pointer arithmetic.
    logic [7:0] entry_mask [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign valid_next[gi] =
                (valid_reg[gi] && !(pop && (rd_ptr_reg == PTR_W'(gi)))) ||
                (push && (wr_ptr_reg == PTR_W'(gi)));
            assign entry_mask[gi] = valid_reg[gi] ? (8'b1 << dest_mem[gi]) : 8'h00;
        end
    endgenerate

    always_comb begin
        pend_mask = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            pend_mask = pend_mask | entry_mask[i];
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            starve_reg <= '0;
            stall_reg  <= 1'b0;
            drop_reg   <= 1'b0;
            wen_reg    <= 1'b0;
            dest_reg   <= 3'd0;
            data_reg   <= 32'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= valid_next;
            starve_reg <= starve_next;
            stall_reg  <= stall_next;
            drop_reg   <= drop_next;
            wen_reg    <= wen_next;
            dest_reg   <= dest_next;
            data_reg   <= data_next;
        end
    end

    // Storage needs no reset: valid_reg gates every use of its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_mem[wr_ptr_reg] <= ld_dest;
            data_mem[wr_ptr_reg] <= ld_data;
        end
    end

    assign wEnable   = wen_reg;
    assign DestReg   = dest_reg;
    assign WBDataIN  = data_reg;
    assign alu_stall = stall_reg;
    assign drop_err  = drop_reg;

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed phases, each pushing its
// hand-computed write sequence into a scoreboard queue; a negedge monitor
// pops and compares every register-bank write the DUT emits.
module tb_writeback_queue;

    logic        clk;
    logic        rst_n;
    logic        alu_wen;
    logic [2:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [2:0]  ld_dest;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        wEnable;
    logic [2:0]  DestReg;
    logic [31:0] WBDataIN;
    logic        alu_stall;
    logic [7:0]  pend_mask;
    logic        drop_err;

    writeback_queue #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_wen   (alu_wen),
        .alu_dest  (alu_dest),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_dest   (ld_dest),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .wEnable   (wEnable),
        .DestReg   (DestReg),
        .WBDataIN  (WBDataIN),
        .alu_stall (alu_stall),
        .pend_mask (pend_mask),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  dest;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic expect_wr(input logic [2:0] d, input logic [31:0] v);
        wr_t w;
        w.dest = d;
        w.data = v;
        exp_q.push_back(w);
    endtask

    // Outputs observed after this returns reflect the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one line per write.
    always @(negedge clk) begin
        if (wEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=dest %0d data %h required=no write t=%0t",
                         DestReg, WBDataIN, $time);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                checks++;
                if (DestReg !== w.dest || WBDataIN !== w.data) begin
                    failures++;
                    $display("FAIL sb_write actual=dest %0d data %h required=dest %0d data %h t=%0t",
                             DestReg, WBDataIN, w.dest, w.data, $time);
                end else begin
                    $display("write dest=%0d data=%h t=%0t", DestReg, WBDataIN, $time);
                end
            end
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        alu_wen  = 1'b0;
        alu_dest = 3'd0;
        alu_data = 32'd0;
        ld_valid = 1'b0;
        ld_dest  = 3'd0;
        ld_data  = 32'd0;

        // ---------- reset state ----------
        tick();
        tick();
        chk("rst_wen",   {31'd0, wEnable},   32'd0);
        chk("rst_dest",  {29'd0, DestReg},   32'd0);
        chk("rst_data",  WBDataIN,           32'd0);
        chk("rst_stall", {31'd0, alu_stall}, 32'd0);
        chk("rst_drop",  {31'd0, drop_err},  32'd0);
        chk("rst_pend",  {24'd0, pend_mask}, 32'd0);
        chk("rst_ready", {31'd0, ld_ready},  32'd1);
        rst_n = 1'b1;
        tick();
        tick();
        tick();

        // ---------- ALU only ----------
        expect_wr(3'd5, 32'hDEADBEEF);
        alu_wen = 1'b1; alu_dest = 3'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_wen = 1'b0;
        chk("alu_wen1",  {31'd0, wEnable}, 32'd1);
        chk("alu_dest",  {29'd0, DestReg}, 32'd5);
        chk("alu_data",  WBDataIN,         32'hDEADBEEF);
        tick();
        chk("alu_wen0",  {31'd0, wEnable}, 32'd0);

        // ---------- load latency on an empty FIFO ----------
        expect_wr(3'd2, 32'h12345678);
        ld_valid = 1'b1; ld_dest = 3'd2; ld_data = 32'h12345678;
        tick();
        ld_valid = 1'b0;
`ifdef WBQ_BYPASS_EN
        chk("byp_wen",   {31'd0, wEnable},   32'd1);
        chk("byp_pend",  {24'd0, pend_mask}, 32'd0);
`else
        chk("ld_wen_n",  {31'd0, wEnable},   32'd0);
        chk("ld_pend_n", {24'd0, pend_mask}, 32'h04);
        tick();
        chk("ld_wen_n1", {31'd0, wEnable},   32'd1);
`endif
        chk("ld_dest",   {29'd0, DestReg},   32'd2);
        tick();
        chk("ld_idle",   {31'd0, wEnable},   32'd0);

        // ---------- fill under continuous ALU traffic ----------
        for (int i = 1; i <= 4; i++) expect_wr(3'd7, 32'hA000_0000 + i);
        for (int i = 1; i <= 4; i++) expect_wr(3'(i), 32'h1000_0000 + i);
        for (int i = 1; i <= 4; i++) begin
            alu_wen = 1'b1; alu_dest = 3'd7; alu_data = 32'hA000_0000 + i;
            ld_valid = 1'b1; ld_dest = 3'(i); ld_data = 32'h1000_0000 + i;
            tick();
            chk($sformatf("fill_stall%0d", i), {31'd0, alu_stall}, (i == 4) ? 32'd1 : 32'd0);
        end
        alu_wen = 1'b0; ld_valid = 1'b0;
        chk("fill_ready", {31'd0, ld_ready},  32'd0);
        chk("fill_pend",  {24'd0, pend_mask}, 32'h1E);
        tick();
        chk("fill_pop_dest", {29'd0, DestReg},   32'd1);
        chk("fill_unstall",  {31'd0, alu_stall}, 32'd0);
        chk("fill_drop",     {31'd0, drop_err},  32'd0);
        chk("fill_ready2",   {31'd0, ld_ready},  32'd1);
        chk("fill_pend2",    {24'd0, pend_mask}, 32'h1C);
        tick();
        tick();
        tick();
        tick();
        chk("fill_drained",  {24'd0, pend_mask}, 32'h00);
        chk("fill_idle",     {31'd0, wEnable},   32'd0);

        // ---------- ALU write dropped during stall ----------
        for (int i = 1; i <= 4; i++) expect_wr(3'd6, 32'hB000_0000 + i);
        expect_wr(3'd3, 32'h3333_0003);
        for (int i = 1; i <= 4; i++) begin
            alu_wen = 1'b1; alu_dest = 3'd6; alu_data = 32'hB000_0000 + i;
            ld_valid = (i == 1); ld_dest = 3'd3; ld_data = 32'h3333_0003;
            tick();
        end
        ld_valid = 1'b0;
        chk("drop_stall", {31'd0, alu_stall}, 32'd1);
        alu_dest = 3'd0; alu_data = 32'hDEAD_0BAD;
        tick();
        alu_wen = 1'b0;
        chk("drop_data",   WBDataIN,           32'h3333_0003);
        chk("drop_err1",   {31'd0, drop_err},  32'd1);
        chk("drop_unstl",  {31'd0, alu_stall}, 32'd0);
        tick();
        chk("drop_idle",   {31'd0, wEnable},   32'd0);

        // ---------- pointer wrap, push order kept ----------
        for (int i = 1; i <= 3; i++) expect_wr(3'd4, 32'hC000_0000 + i);
        for (int i = 0; i < 10; i++) expect_wr(3'(i % 8), 32'h5000_0000 + i);
        for (int i = 0; i < 10; i++) begin
            alu_wen = (i < 3); alu_dest = 3'd4; alu_data = 32'hC000_0001 + i;
            ld_valid = 1'b1; ld_dest = 3'(i % 8); ld_data = 32'h5000_0000 + i;
            tick();
            chk($sformatf("wrap_ready%0d", i), {31'd0, ld_ready}, 32'd1);
            if (i == 2) chk("wrap_pend", {24'd0, pend_mask}, 32'h07);
        end
        alu_wen = 1'b0; ld_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("wrap_idle",  {31'd0, wEnable},  32'd0);
        chk("drop_sticky", {31'd0, drop_err}, 32'd1);

        // ---------- reset mid-burst with 3 queued loads ----------
        for (int i = 1; i <= 3; i++) expect_wr(3'd1, 32'hD000_0000 + i);
        for (int i = 1; i <= 3; i++) begin
            alu_wen = 1'b1; alu_dest = 3'd1; alu_data = 32'hD000_0000 + i;
            ld_valid = 1'b1; ld_dest = 3'(i + 3); ld_data = 32'h6000_0000 + i;
            tick();
        end
        alu_wen = 1'b0; ld_valid = 1'b0;
        chk("mid_pend", {24'd0, pend_mask}, 32'h70);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen",   {31'd0, wEnable},   32'd0);
        chk("mid_rst_pend",  {24'd0, pend_mask}, 32'h00);
        chk("mid_rst_ready", {31'd0, ld_ready},  32'd1);
        chk("mid_rst_drop",  {31'd0, drop_err},  32'd0);
        chk("mid_rst_data",  WBDataIN,           32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post_rst_wen%0d", i), {31'd0, wEnable}, 32'd0);
        end
        chk("post_rst_pend", {24'd0, pend_mask}, 32'h00);

        @(negedge clk);
        #1;
        chk("sb_remaining", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
